// File: rtl/barker_pkg.sv
// rtl/barker_pkg.sv - shared constants, FSM encoding and helpers for the Barker frame arbiter
package barker_pkg;

    localparam logic [10:0] BARKER11        = 11'b11100010010;
    localparam int          TIMEOUT_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        STREAM   = 2'd1,
        WAIT_RES = 2'd2,
        EMIT     = 2'd3
    } arb_state_t;

    function automatic int wrap_inc(input int value, input int modulus);
        return (value + 1 >= modulus) ? 0 : value + 1;
    endfunction

endpackage

// File: rtl/barker_frame_arbiter_if.sv
// rtl/barker_frame_arbiter_if.sv - requester, correlator and result streams of the Barker frame arbiter
interface barker_frame_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
);

    logic [N_REQ-1:0] s_tdata;
    logic [N_REQ-1:0] s_tvalid;
    logic [N_REQ-1:0] s_tlast;
    logic [N_REQ-1:0] s_tready;

    logic             c_tdata;
    logic             c_tvalid;
    logic             c_tlast;
    logic             c_tready;

    logic             r_tuser;
    logic             r_tvalid;
    logic             r_tready;

    logic             o_tvalid;
    logic             o_match;
    logic             o_timeout;
    logic [ID_W-1:0]  o_id;
    logic             o_tready;

    // master: the arbiter itself; slave: requesters, correlator and result consumer
    modport master (
        input  s_tdata, s_tvalid, s_tlast,
        output s_tready,
        output c_tdata, c_tvalid, c_tlast,
        input  c_tready,
        input  r_tuser, r_tvalid,
        output r_tready,
        output o_tvalid, o_match, o_timeout, o_id,
        input  o_tready
    );

    modport slave (
        output s_tdata, s_tvalid, s_tlast,
        input  s_tready,
        input  c_tdata, c_tvalid, c_tlast,
        output c_tready,
        output r_tuser, r_tvalid,
        input  r_tready,
        input  o_tvalid, o_match, o_timeout, o_id,
        output o_tready
    );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick: first request at or after ptr, wrapping
module rr_arbiter #(
    parameter int N    = 4,
    parameter int ID_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] grant_idx
);

    // Descending scans leave the lowest qualifying index as the last write; the
    // second scan (indices at/after ptr) overrides the wrapped fallback.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant     = '0;
                grant[i]  = 1'b1;
                grant_idx = ID_W'(i);
            end
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i] && (i >= int'(ptr))) begin
                grant     = '0;
                grant[i]  = 1'b1;
                grant_idx = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/barker_frame_arbiter.sv
// rtl/barker_frame_arbiter.sv - round-robin arbiter feeding bit-serial frames to a Barker correlator and tagging results
module barker_frame_arbiter
    import barker_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
    parameter int ID_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    barker_frame_arbiter_if.master bus
);

    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    arb_state_t       state;
    arb_state_t       state_next;
    logic [ID_W-1:0]  gnt;
    logic [N_REQ-1:0] gnt_onehot;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  pick_idx;
    logic [N_REQ-1:0] pick_onehot;
    logic [CNT_W-1:0] wait_cnt;
    logic             res_match;
    logic             res_timeout;
    logic             any_req;
    logic             last_accepted;
    logic             wait_expired;

    rr_arbiter #(
        .N    (N_REQ),
        .ID_W (ID_W)
    ) u_rr_arbiter (
        .req       (bus.s_tvalid),
        .ptr       (rr_ptr),
        .grant     (pick_onehot),
        .grant_idx (pick_idx)
    );

    assign any_req       = |bus.s_tvalid;
    assign last_accepted = bus.s_tvalid[gnt] & bus.c_tready & bus.s_tlast[gnt];
    assign wait_expired  = (wait_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (any_req)                        state_next = STREAM;
            STREAM:   if (last_accepted)                  state_next = WAIT_RES;
            WAIT_RES: if (bus.r_tvalid || wait_expired)   state_next = EMIT;
            EMIT:     if (bus.o_tready)                   state_next = IDLE;
            default:                                      state_next = IDLE;
        endcase
    end

    // Grant, round-robin pointer, response timer and latched result.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            gnt         <= '0;
            gnt_onehot  <= '0;
            rr_ptr      <= '0;
            wait_cnt    <= '0;
            res_match   <= 1'b0;
            res_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt        <= pick_idx;
                        gnt_onehot <= pick_onehot;
                    end
                end
                STREAM: begin
                    if (last_accepted) begin
                        rr_ptr   <= ID_W'(wrap_inc(int'(gnt), N_REQ));
                        wait_cnt <= '0;
                    end
                end
                WAIT_RES: begin
                    // A result arriving on the final counted cycle still beats the timeout.
                    if (bus.r_tvalid) begin
                        res_match   <= bus.r_tuser;
                        res_timeout <= 1'b0;
                    end else if (wait_expired) begin
                        res_match   <= 1'b0;
                        res_timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.s_tready  = '0;
        bus.c_tdata   = 1'b0;
        bus.c_tvalid  = 1'b0;
        bus.c_tlast   = 1'b0;
        bus.r_tready  = 1'b0;
        bus.o_tvalid  = 1'b0;
        bus.o_match   = 1'b0;
        bus.o_timeout = 1'b0;
        bus.o_id      = '0;
        case (state)
            STREAM: begin
                bus.s_tready = gnt_onehot & {N_REQ{bus.c_tready}};
                bus.c_tdata  = bus.s_tdata[gnt];
                bus.c_tvalid = bus.s_tvalid[gnt];
                bus.c_tlast  = bus.s_tlast[gnt];
                bus.r_tready = 1'b1;
            end
            WAIT_RES: begin
                bus.r_tready = 1'b1;
            end
            EMIT: begin
                bus.o_tvalid  = 1'b1;
                bus.o_match   = res_match;
                bus.o_timeout = res_timeout;
                bus.o_id      = gnt;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/barker_frame_arbiter.md
BARKER_FRAME_ARBITER -- requirements
Module: barker_frame_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of bit-serial requester streams (1..8).
REQ-002 SHALL have parameter TIMEOUT, default 16, max cycles in WAIT_RES before a result is forced.
REQ-003 SHALL have parameter ID_W, default $clog2(N_REQ) (minimum 1), requester-id width.
REQ-004 i_clk  input  1  single clock, all logic on rising edge.
REQ-005 i_rst_n  input  1  reset, synchronous, active-low.
REQ-006 s_tdata  input  N_REQ  per-requester data bit.
REQ-007 s_tvalid  input  N_REQ  per-requester beat valid.
REQ-008 s_tlast  input  N_REQ  per-requester last beat of frame.
REQ-009 s_tready  output  N_REQ  per-requester beat accept.
REQ-010 c_tdata / c_tvalid / c_tlast  output  1 each  bit stream to the correlator slave port.
REQ-011 c_tready  input  1  correlator slave ready.
REQ-012 r_tuser / r_tvalid  input  1 each  correlator result (match flag) and result valid.
REQ-013 r_tready  output  1  ready driven to the correlator master port.
REQ-014 o_tvalid  output  1  tagged result valid.
REQ-015 o_match  output  1  1 = frame matched the 11-bit Barker sequence.
REQ-016 o_timeout  output  1  1 = no correlator result within TIMEOUT.
REQ-017 o_id  output  ID_W  requester index owning the result.
REQ-018 o_tready  input  1  consumer accept of tagged result.

Function
REQ-019 SHALL run an FSM with states IDLE, STREAM, WAIT_RES, EMIT; exactly one frame in flight at a time.
REQ-020 In IDLE, when any s_tvalid is set, SHALL register grant g = first set index at or after rr pointer (wrapping) and enter STREAM next cycle.
REQ-021 In STREAM, c_tdata/c_tvalid/c_tlast SHALL equal s_*[g] combinationally; s_tready[g] = c_tready; all other s_tready = 0.
REQ-022 Outside STREAM, s_tready SHALL be all-zero and c_tvalid = 0.
REQ-023 Grant SHALL be held while s_tvalid[g] is low mid-frame (no re-arbitration until tlast).
REQ-024 On accepted beat (c_tvalid & c_tready & c_tlast) SHALL enter WAIT_RES and set rr pointer = (g+1) mod N_REQ.
REQ-025 r_tready SHALL be 1 in STREAM and WAIT_RES, 0 in IDLE and EMIT.
REQ-026 In WAIT_RES, a cycle counter SHALL start at 0; r_tvalid latches o_match = r_tuser, o_timeout = 0, enters EMIT.
REQ-027 If counter reaches TIMEOUT-1 without r_tvalid, SHALL enter EMIT with o_match = 0, o_timeout = 1.
REQ-028 Simultaneous r_tvalid and timeout: the result SHALL win (o_timeout = 0).
REQ-029 r_tvalid in IDLE or STREAM SHALL be discarded.
REQ-030 In EMIT, o_tvalid = 1 with o_match, o_timeout, o_id = g stable until o_tready; on handshake return to IDLE.
REQ-031 o_tvalid SHALL be 0 in all states except EMIT.
REQ-032 Single-beat frame (tlast on first beat) SHALL be legal.
REQ-033 Latency: first forwardable beat 1 cycle after s_tvalid seen in IDLE; EMIT entered 1 cycle after r_tvalid.

Reset
REQ-034 On i_rst_n = 0 at a clock edge: state IDLE, rr pointer 0, counter 0, s_tready 0, c_tvalid 0, r_tready 0, o_tvalid/o_match/o_timeout 0, o_id 0.
REQ-035 Reset mid-frame or mid-EMIT SHALL abandon the frame with no output emitted.

Structure
REQ-036 Package barker_pkg SHALL hold the Barker-11 constant 11'b11100010010, the arb_state_t enum and the TIMEOUT default.
REQ-037 Round-robin pick SHALL be a sub-module rr_arbiter (request vector, pointer in; one-hot grant and index out, combinational).
REQ-038 Whole design 120-400 lines, fully synchronous; no latches.

Verification
REQ-039 Req 0 sends 11100010010 with tlast, correlator returns r_tuser = 1 -> one o_tvalid with o_match = 1, o_id = 0, o_timeout = 0.
REQ-040 Reqs 1 and 3 assert s_tvalid simultaneously from reset -> frame order 1, 3, then 1 again on re-request; never interleaved.
REQ-041 r_tvalid withheld after tlast -> o_timeout = 1, o_match = 0 exactly TIMEOUT cycles after WAIT_RES entry; simultaneous r_tvalid on last cycle gives o_timeout = 0.
REQ-042 o_tready held low 5 cycles in EMIT -> outputs stable, no new grant, s_tready all-zero.
REQ-043 s_tvalid[g] gaps plus c_tready backpressure mid-frame -> beats forwarded in order, no loss or duplication.
REQ-044 i_rst_n pulsed low during STREAM at beat 6 -> all outputs 0 next cycle, no EMIT, next frame granted to req 0.
